// File: rtl/bram_port_arbiter.sv
// Round-robin arbiter sharing one single-port BRAM among NUM_REQ engines, with
// tagged read-data return and an ownership lock for read-modify-write sequences.
module bram_port_arbiter #(
    parameter int NUM_REQ    = 3,
    parameter int ADDR_WIDTH = 13,
    parameter int DATA_WIDTH = 32,
    parameter int READ_LAT   = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ-1:0]            req_we,
    input  logic [NUM_REQ-1:0]            req_lock,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]            gnt,
    output logic [NUM_REQ-1:0]            rvalid,
    output logic [DATA_WIDTH-1:0]         rdata,
    output logic [ADDR_WIDTH-1:0]         bram_addr,
    output logic                          bram_we,
    output logic [DATA_WIDTH-1:0]         bram_wdata,
    input  logic [DATA_WIDTH-1:0]         bram_rdata,
    output logic                          busy
);
    localparam int IDX_W = $clog2(NUM_REQ);

    function automatic logic [NUM_REQ-1:0] to_onehot(input logic [IDX_W-1:0] idx);
        logic [NUM_REQ-1:0] vec;
        vec      = {NUM_REQ{1'b0}};
        vec[idx] = 1'b1;
        return vec;
    endfunction

    function automatic logic [IDX_W-1:0] rr_index(input logic [IDX_W-1:0] base, input int offset);
        int sum;
        sum = int'(base) + offset;
        if (sum >= NUM_REQ) begin
            sum = sum - NUM_REQ;
        end else begin
            sum = sum;
        end
        return IDX_W'(sum);
    endfunction

    logic [IDX_W-1:0]               rr_ptr_r;
    logic [IDX_W-1:0]               rr_ptr_nxt_s;
    logic [IDX_W-1:0]               lock_owner_r;
    logic [IDX_W-1:0]               lock_owner_nxt_s;
    logic [IDX_W-1:0]               sel_s;
    logic                           lock_valid_r;
    logic                           lock_valid_nxt_s;
    logic                           found_s;
    logic                           busy_nxt_s;
    logic                           we_nxt_s;
    logic [NUM_REQ-1:0]             elig_s;
    logic [NUM_REQ-1:0]             gnt_nxt_s;
    logic [ADDR_WIDTH-1:0]          addr_nxt_s;
    logic [DATA_WIDTH-1:0]          wdata_nxt_s;
    logic [READ_LAT:0][NUM_REQ-1:0] pipe_r;
    logic [READ_LAT:0][NUM_REQ-1:0] pipe_nxt_s;

    // Eligibility, round-robin pick and next state of port, pointer, lock and read tags
    always_comb begin
        elig_s = req & ~gnt;
        if (lock_valid_r) begin
            elig_s = elig_s & to_onehot(lock_owner_r);
        end else begin
            elig_s = req & ~gnt;
        end
        found_s = 1'b0;
        sel_s   = {IDX_W{1'b0}};
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found_s && elig_s[rr_index(rr_ptr_r, k)]) begin
                found_s = 1'b1;
                sel_s   = rr_index(rr_ptr_r, k);
            end else begin
                found_s = found_s;
            end
        end
        gnt_nxt_s   = found_s ? to_onehot(sel_s) : {NUM_REQ{1'b0}};
        addr_nxt_s  = found_s ? req_addr[int'(sel_s)*ADDR_WIDTH +: ADDR_WIDTH] : bram_addr;
        we_nxt_s    = found_s ? req_we[sel_s] : 1'b0;
        wdata_nxt_s = found_s ? req_wdata[int'(sel_s)*DATA_WIDTH +: DATA_WIDTH] : bram_wdata;
        // The pointer freezes while a lock is held so the owner's sequence is not a turn
        rr_ptr_nxt_s     = (found_s && !lock_valid_r) ? rr_index(sel_s, 1) : rr_ptr_r;
        lock_valid_nxt_s = found_s ? req_lock[sel_s] : lock_valid_r;
        lock_owner_nxt_s = (found_s && req_lock[sel_s]) ? sel_s : lock_owner_r;
        pipe_nxt_s[0]    = (found_s && !req_we[sel_s]) ? to_onehot(sel_s) : {NUM_REQ{1'b0}};
        for (int s = 1; s <= READ_LAT; s++) begin
            pipe_nxt_s[s] = pipe_r[s-1];
        end
        busy_nxt_s = lock_valid_nxt_s | (|pipe_nxt_s);
    end

    // Port drive, arbitration state and read-return registers
    always_ff @(posedge clk) begin
        if (rst) begin
            gnt          <= {NUM_REQ{1'b0}};
            rvalid       <= {NUM_REQ{1'b0}};
            rdata        <= {DATA_WIDTH{1'b0}};
            bram_addr    <= {ADDR_WIDTH{1'b0}};
            bram_we      <= 1'b0;
            bram_wdata   <= {DATA_WIDTH{1'b0}};
            busy         <= 1'b0;
            rr_ptr_r     <= {IDX_W{1'b0}};
            lock_valid_r <= 1'b0;
            lock_owner_r <= {IDX_W{1'b0}};
            pipe_r       <= {((READ_LAT+1)*NUM_REQ){1'b0}};
        end else begin
            gnt          <= gnt_nxt_s;
            bram_addr    <= addr_nxt_s;
            bram_we      <= we_nxt_s;
            bram_wdata   <= wdata_nxt_s;
            busy         <= busy_nxt_s;
            rr_ptr_r     <= rr_ptr_nxt_s;
            lock_valid_r <= lock_valid_nxt_s;
            lock_owner_r <= lock_owner_nxt_s;
            pipe_r       <= pipe_nxt_s;
            rvalid       <= pipe_r[READ_LAT];
            if (|pipe_r[READ_LAT]) begin
                rdata <= bram_rdata;
            end else begin
                rdata <= rdata;
            end
        end
    end
endmodule
